mac_row_seq: RTL

- Sequencer in front of one MAC row (COL tiles, 2-bit instruction bus: bit0 = kernel load, bit1 = execute).
- On a start pulse, loads COL weight words into the row from a valid/ready weight source.
- Then streams ACT_LEN activation words from a valid/ready activation source with the execute instruction.
- Then waits until the last column has reported ACT_LEN valid outputs, and pulses done.

---
 rtl/mac_row_seq_pkg.sv | 25 ++
 rtl/mac_row_seq_cnt.sv | 32 +++
 rtl/mac_row_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mac_row_seq_pkg.sv
// Shared definitions for the MAC row sequencer: row instruction codes,
// FSM state encoding and the row word width.
package mac_row_seq_pkg;

  localparam int BW_DEFAULT              = 4;
  localparam int INDEX_SELECTION_DEFAULT = 2;
  localparam int ROW_W_DEFAULT           = BW_DEFAULT * INDEX_SELECTION_DEFAULT;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int row_width(input int bw, input int isel);
    return bw * isel;
  endfunction

endpackage

// File: rtl/mac_row_seq_cnt.sv
// Clear/enable counter that saturates at i_limit; o_tc_next flags that the
// count equals the limit after this cycle's update.
module mac_row_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_tc_next
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_tc_next = (r_cnt == i_limit) || (i_en && ((r_cnt + ONE) == i_limit));

endmodule

// File: rtl/mac_row_seq.sv
// Sequencer feeding one MAC row: loads COL weight words, streams act_len
// activation words, then waits for act_len last-column outputs before done.
module mac_row_seq
  import mac_row_seq_pkg::*;
#(
  parameter int BW              = BW_DEFAULT,
  parameter int INDEX_SELECTION = INDEX_SELECTION_DEFAULT,
  parameter int COL             = 8,
  parameter int LEN_BW          = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [LEN_BW-1:0]             cfg_act_len,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [BW*INDEX_SELECTION-1:0] w_data,
  input  logic                          x_valid,
  output logic                          x_ready,
  input  logic [BW*INDEX_SELECTION-1:0] x_data,
  output logic [BW*INDEX_SELECTION-1:0] row_in_w,
  output logic [1:0]                    row_inst_w,
  input  logic [COL-1:0]                row_valid,
  output logic                          busy,
  output logic                          done,
  output logic [LEN_BW-1:0]             out_cnt
);

  localparam int ROW_W  = row_width(BW, INDEX_SELECTION);
  localparam int LCNT_W = $clog2(COL + 1);
  localparam logic [LCNT_W-1:0] LOAD_LIMIT = LCNT_W'(COL);

  state_t             r_state;
  state_t             w_state_next;
  logic [LEN_BW-1:0]  r_act_len;
  logic [ROW_W-1:0]   r_row_in;
  logic [ROW_W-1:0]   w_row_in_next;
  logic [1:0]         r_row_inst;
  logic [1:0]         w_row_inst_next;
  logic               w_wgt_hs;
  logic               w_act_hs;
  logic               w_start_acc;
  logic               w_out_en;
  logic [LCNT_W-1:0]  w_load_cnt;
  logic [LEN_BW-1:0]  w_exec_cnt;
  logic [LEN_BW-1:0]  w_out_cnt;
  logic               w_load_tc_next;
  logic               w_exec_tc_next;
  logic               w_out_tc_next;
  logic               w_unused;

  assign w_ready     = (r_state == ST_LOAD);
  assign x_ready     = (r_state == ST_EXEC);
  assign w_wgt_hs    = w_valid & w_ready;
  assign w_act_hs    = x_valid & x_ready;
  assign w_start_acc = (r_state == ST_IDLE) & start;
  // A last-column valid on the EXEC->DRAIN edge still lands in EXEC, so it counts.
  assign w_out_en    = row_valid[COL-1] & ((r_state == ST_EXEC) | (r_state == ST_DRAIN));

  mac_row_seq_cnt #(.W(LCNT_W)) u_load_cnt (
    .clk(clk), .i_rst_n(reset), .i_clr(w_start_acc), .i_en(w_wgt_hs),
    .i_limit(LOAD_LIMIT), .o_cnt(w_load_cnt), .o_tc_next(w_load_tc_next)
  );

  mac_row_seq_cnt #(.W(LEN_BW)) u_exec_cnt (
    .clk(clk), .i_rst_n(reset), .i_clr(w_start_acc), .i_en(w_act_hs),
    .i_limit(r_act_len), .o_cnt(w_exec_cnt), .o_tc_next(w_exec_tc_next)
  );

  mac_row_seq_cnt #(.W(LEN_BW)) u_out_cnt (
    .clk(clk), .i_rst_n(reset), .i_clr(w_start_acc), .i_en(w_out_en),
    .i_limit(r_act_len), .o_cnt(w_out_cnt), .o_tc_next(w_out_tc_next)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_LOAD;
      ST_LOAD:  if (w_load_tc_next) w_state_next = (r_act_len == '0) ? ST_DONE : ST_EXEC;
      ST_EXEC:  if (w_exec_tc_next) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_out_tc_next) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_row_in_next   = '0;
    w_row_inst_next = INST_NOP;
    if (w_wgt_hs) begin
      w_row_in_next   = w_data;
      w_row_inst_next = INST_LOAD;
    end else if (w_act_hs) begin
      w_row_in_next   = x_data;
      w_row_inst_next = INST_EXEC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_act_len  <= '0;
      r_row_in   <= '0;
      r_row_inst <= INST_NOP;
    end else begin
      r_state    <= w_state_next;
      r_row_in   <= w_row_in_next;
      r_row_inst <= w_row_inst_next;
      if (w_start_acc) r_act_len <= cfg_act_len;
    end
  end

  assign row_in_w   = r_row_in;
  assign row_inst_w = r_row_inst;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign out_cnt    = w_out_cnt;
  assign w_unused   = ^{w_load_cnt, w_exec_cnt, row_valid[COL-2:0]};

endmodule
